// File: rtl/flt_norm_round_decomposable.sv
// Two-stage normalize/round/clamp for the decomposable float adder (1x32b, 2x16b or 4x8b lanes per beat).
// Latency 2 cycles with full-throughput valid/ready; a stalled output holds both stages and drops in_ready.
package pe_pkg;
  localparam int PRECISION_CONFIG_L = 2;
  localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_32B = 2'd0;
  localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_16B = 2'd1;
  localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_8B  = 2'd2;
endpackage

module flt_norm_round_lane #(
  parameter int M = 4,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s1_ld,
  input  logic         s2_ld,
  input  logic         lane_en,
  input  logic [W:0]   exp_in,
  input  logic [M+1:0] mant_in,
  output logic [W-1:0] exp_out,
  output logic [M-1:0] mant_out,
  output logic         ovf_set,
  output logic         udf_set
);
  localparam int EMAX = 2**(W-1) - 1;
  localparam int EMIN = -(2**(W-1));

  logic [M-1:0] nmant_q, nmant_d;
  logic         guard_q, guard_d;
  logic         sticky_q, sticky_d;
  logic         zero_q, zero_d;
  // Two extra exponent bits absorb both the normalize and the rounding increment.
  logic [W+1:0] nexp_q, nexp_d;
  logic [W-1:0] exp_out_q, exp_out_d;
  logic [M-1:0] mant_out_q, mant_out_d;

  logic         inc;
  logic [M:0]   rsum;
  logic [W+1:0] rexp;
  logic [M-1:0] rmant;
  logic [W-1:0] cexp;
  logic [M-1:0] cmant;

  always_comb begin : normalize
    nmant_d  = nmant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    zero_d   = zero_q;
    nexp_d   = nexp_q;
    if (s1_ld) begin
      zero_d = (mant_in == '0);
      if (mant_in[M+1]) begin
        nmant_d  = mant_in[M+1:2];
        guard_d  = mant_in[1];
        sticky_d = mant_in[0];
        nexp_d   = {exp_in[W], exp_in} + (W+2)'(1);
      end else begin
        nmant_d  = mant_in[M:1];
        guard_d  = mant_in[0];
        sticky_d = 1'b0;
        nexp_d   = {exp_in[W], exp_in};
      end
    end
  end

  always_comb begin : round_clamp
    inc   = guard_q & (sticky_q | nmant_q[0]);
    rsum  = {1'b0, nmant_q} + (M+1)'(inc);
    rexp  = nexp_q + (W+2)'(rsum[M]);
    rmant = rsum[M] ? {1'b1, {(M-1){1'b0}}} : rsum[M-1:0];
    cexp    = rexp[W-1:0];
    cmant   = rmant;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (!lane_en) begin
      cexp  = '0;
      cmant = '0;
    end else if (zero_q) begin
      cexp  = W'(EMIN);
      cmant = '0;
    end else if ($signed(rexp) > $signed((W+2)'(EMAX))) begin
      cexp    = W'(EMAX);
      cmant   = '1;
      ovf_set = 1'b1;
    end else if ($signed(rexp) < $signed((W+2)'(EMIN))) begin
      cexp    = W'(EMIN);
      cmant   = '0;
      udf_set = 1'b1;
    end
    exp_out_d  = s2_ld ? cexp  : exp_out_q;
    mant_out_d = s2_ld ? cmant : mant_out_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmant_q    <= '0;
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
      zero_q     <= 1'b0;
      nexp_q     <= '0;
      exp_out_q  <= '0;
      mant_out_q <= '0;
    end else begin
      nmant_q    <= nmant_d;
      guard_q    <= guard_d;
      sticky_q   <= sticky_d;
      zero_q     <= zero_d;
      nexp_q     <= nexp_d;
      exp_out_q  <= exp_out_d;
      mant_out_q <= mant_out_d;
    end
  end

  assign exp_out  = exp_out_q;
  assign mant_out = mant_out_q;
endmodule

module flt_norm_round_decomposable
  import pe_pkg::*;
#(
  parameter int MANT_FULL_L  = 24,
  parameter int MANT_HALF_L  = 11,
  parameter int MANT_QUART_L = 4,
  parameter int EXP_FULL_W   = 9,
  parameter int EXP_HALF_W   = 6,
  parameter int EXP_QUART_W  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PRECISION_CONFIG_L-1:0]      mode,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [EXP_FULL_W:0]                exp_full_in,
  input  logic [MANT_FULL_L+1:0]             mant_full_in,
  input  logic [1:0][EXP_HALF_W:0]           exp_half_in,
  input  logic [1:0][MANT_HALF_L+1:0]        mant_half_in,
  input  logic [3:0][EXP_QUART_W:0]          exp_quart_in,
  input  logic [3:0][MANT_QUART_L+1:0]       mant_quart_in,
  input  logic                               clr_flags,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [PRECISION_CONFIG_L-1:0]      mode_out,
  output logic [EXP_FULL_W-1:0]              exp_full_out,
  output logic [MANT_FULL_L-1:0]             mant_full_out,
  output logic [1:0][EXP_HALF_W-1:0]         exp_half_out,
  output logic [1:0][MANT_HALF_L-1:0]        mant_half_out,
  output logic [3:0][EXP_QUART_W-1:0]        exp_quart_out,
  output logic [3:0][MANT_QUART_L-1:0]       mant_quart_out,
  output logic [3:0]                         ovf_flags,
  output logic [3:0]                         udf_flags
);
  logic                          s1_valid_q, s1_valid_d;
  logic                          s2_valid_q, s2_valid_d;
  logic [PRECISION_CONFIG_L-1:0] s1_mode_q, s1_mode_d;
  logic [PRECISION_CONFIG_L-1:0] mode_out_q, mode_out_d;
  logic [3:0]                    ovf_flags_q, ovf_flags_d;
  logic [3:0]                    udf_flags_q, udf_flags_d;

  logic       s1_adv, s1_ld, s2_ld;
  logic       full_en, half_en, quart_en;
  logic       f_ovf, f_udf;
  logic [1:0] h_ovf, h_udf;
  logic [3:0] q_ovf, q_udf;
  logic [3:0] ovf_set, udf_set;

  always_comb begin : ctrl
    s1_adv     = !s2_valid_q || out_ready;
    in_ready   = !s1_valid_q || s1_adv;
    s1_ld      = in_valid && in_ready;
    s2_ld      = s1_valid_q && s1_adv;
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
    s1_mode_d  = s1_ld ? mode : s1_mode_q;
    mode_out_d = s2_ld ? s1_mode_q : mode_out_q;
    full_en    = (s1_mode_q == PRECISION_CONFIG_32B);
    half_en    = (s1_mode_q == PRECISION_CONFIG_16B);
    quart_en   = (s1_mode_q == PRECISION_CONFIG_8B);
  end

  flt_norm_round_lane #(.M(MANT_FULL_L), .W(EXP_FULL_W)) u_full (
    .clk      (clk),
    .rst      (rst),
    .s1_ld    (s1_ld),
    .s2_ld    (s2_ld),
    .lane_en  (full_en),
    .exp_in   (exp_full_in),
    .mant_in  (mant_full_in),
    .exp_out  (exp_full_out),
    .mant_out (mant_full_out),
    .ovf_set  (f_ovf),
    .udf_set  (f_udf)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    flt_norm_round_lane #(.M(MANT_HALF_L), .W(EXP_HALF_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .s1_ld    (s1_ld),
      .s2_ld    (s2_ld),
      .lane_en  (half_en),
      .exp_in   (exp_half_in[gi]),
      .mant_in  (mant_half_in[gi]),
      .exp_out  (exp_half_out[gi]),
      .mant_out (mant_half_out[gi]),
      .ovf_set  (h_ovf[gi]),
      .udf_set  (h_udf[gi])
    );
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_quart
    flt_norm_round_lane #(.M(MANT_QUART_L), .W(EXP_QUART_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .s1_ld    (s1_ld),
      .s2_ld    (s2_ld),
      .lane_en  (quart_en),
      .exp_in   (exp_quart_in[gi]),
      .mant_in  (mant_quart_in[gi]),
      .exp_out  (exp_quart_out[gi]),
      .mant_out (mant_quart_out[gi]),
      .ovf_set  (q_ovf[gi]),
      .udf_set  (q_udf[gi])
    );
  end

  // Disabled lanes never raise a set, so the flag lanes can simply be OR-merged.
  always_comb begin : flags
    ovf_set     = {q_ovf[3], q_ovf[2] | h_ovf[1], q_ovf[1], q_ovf[0] | h_ovf[0] | f_ovf};
    udf_set     = {q_udf[3], q_udf[2] | h_udf[1], q_udf[1], q_udf[0] | h_udf[0] | f_udf};
    ovf_flags_d = (clr_flags ? 4'b0 : ovf_flags_q) | (s2_ld ? ovf_set : 4'b0);
    udf_flags_d = (clr_flags ? 4'b0 : udf_flags_q) | (s2_ld ? udf_set : 4'b0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_mode_q   <= '0;
      mode_out_q  <= '0;
      ovf_flags_q <= '0;
      udf_flags_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s1_mode_q   <= s1_mode_d;
      mode_out_q  <= mode_out_d;
      ovf_flags_q <= ovf_flags_d;
      udf_flags_q <= udf_flags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign mode_out  = mode_out_q;
  assign ovf_flags = ovf_flags_q;
  assign udf_flags = udf_flags_q;
endmodule

// File: tb/tb_flt_norm_round_decomposable.sv
// Scoreboarded bench: directed cases plus randomized beats against an integer reference model.
module tb_flt_norm_round_decomposable;
  import pe_pkg::*;

  localparam int MF = 24, MH = 11, MQ = 4;
  localparam int EF = 9, EH = 6, EQ = 4;

  typedef logic [PRECISION_CONFIG_L-1:0] mode_t;
  typedef struct packed {
    mode_t                 mode;
    logic [EF:0]           ef;
    logic [MF+1:0]         mf;
    logic [1:0][EH:0]      eh;
    logic [1:0][MH+1:0]    mh;
    logic [3:0][EQ:0]      eq;
    logic [3:0][MQ+1:0]    mq;
  } in_t;
  typedef struct packed {
    mode_t                 mode;
    logic [EF-1:0]         ef;
    logic [MF-1:0]         mf;
    logic [1:0][EH-1:0]    eh;
    logic [1:0][MH-1:0]    mh;
    logic [3:0][EQ-1:0]    eq;
    logic [3:0][MQ-1:0]    mq;
  } out_t;

  logic clk, rst, in_valid, in_ready, clr_flags, out_valid, out_ready;
  mode_t mode, mode_out;
  logic [EF:0] exp_full_in;
  logic [MF+1:0] mant_full_in;
  logic [1:0][EH:0] exp_half_in;
  logic [1:0][MH+1:0] mant_half_in;
  logic [3:0][EQ:0] exp_quart_in;
  logic [3:0][MQ+1:0] mant_quart_in;
  logic [EF-1:0] exp_full_out;
  logic [MF-1:0] mant_full_out;
  logic [1:0][EH-1:0] exp_half_out;
  logic [1:0][MH-1:0] mant_half_out;
  logic [3:0][EQ-1:0] exp_quart_out;
  logic [3:0][MQ-1:0] mant_quart_out;
  logic [3:0] ovf_flags, udf_flags;

  logic rand_mode, rdy_rnd, rdy_fix;
  assign out_ready = rand_mode ? rdy_rnd : rdy_fix;

  out_t exp_q[$];
  int   pop_cyc[$];
  int   checks, errors, cyc, accepted;
  logic [3:0] m_ovf, m_udf;
  out_t mon_act, mon_exp;

  flt_norm_round_decomposable dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .exp_full_in(exp_full_in), .mant_full_in(mant_full_in),
    .exp_half_in(exp_half_in), .mant_half_in(mant_half_in),
    .exp_quart_in(exp_quart_in), .mant_quart_in(mant_quart_in),
    .clr_flags(clr_flags), .out_valid(out_valid), .out_ready(out_ready),
    .mode_out(mode_out), .exp_full_out(exp_full_out), .mant_full_out(mant_full_out),
    .exp_half_out(exp_half_out), .mant_half_out(mant_half_out),
    .exp_quart_out(exp_quart_out), .mant_quart_out(mant_quart_out),
    .ovf_flags(ovf_flags), .udf_flags(udf_flags)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial begin cyc = 0; forever begin @(posedge clk); cyc++; end end
  initial begin rdy_rnd = 1; forever begin @(posedge clk); #1; rdy_rnd = ($urandom_range(0, 3) != 0); end end
  initial begin #600000; $display("FAIL watchdog got timeout want finish"); $fatal(1); end

  // Reference for one lane: m mantissa bits, w exponent bits, v raw {carry,mant,round}.
  function automatic void lane_ref(input int m, input int w, input int e_in, input int v,
                                   output int e_o, output int m_o, output bit ov, output bit ud);
    int mant, g, s, e, emax, emin;
    emax = (1 << (w - 1)) - 1;
    emin = -(1 << (w - 1));
    ov = 0; ud = 0;
    if (v == 0) begin e_o = emin; m_o = 0; return; end
    if (v >= (1 << (m + 1))) begin mant = v / 4; g = (v / 2) % 2; s = v % 2; e = e_in + 1; end
    else begin mant = v / 2; g = v % 2; s = 0; e = e_in; end
    if (g == 1 && (s == 1 || mant % 2 == 1)) mant++;
    if (mant == (1 << m)) begin mant = 1 << (m - 1); e++; end
    if (e > emax) begin e_o = emax; m_o = (1 << m) - 1; ov = 1; end
    else if (e < emin) begin e_o = emin; m_o = 0; ud = 1; end
    else begin e_o = e; m_o = mant; end
  endfunction

  function automatic void ref_beat(input in_t b, output out_t r, output logic [3:0] ov, output logic [3:0] ud);
    int eo, mo;
    bit o, u;
    r = '0; ov = '0; ud = '0;
    r.mode = b.mode;
    if (b.mode == PRECISION_CONFIG_32B) begin
      lane_ref(MF, EF, int'($signed(b.ef)), int'(b.mf), eo, mo, o, u);
      r.ef = EF'(eo); r.mf = MF'(mo); ov[0] = o; ud[0] = u;
    end else if (b.mode == PRECISION_CONFIG_16B) begin
      for (int i = 0; i < 2; i++) begin
        lane_ref(MH, EH, int'($signed(b.eh[i])), int'(b.mh[i]), eo, mo, o, u);
        r.eh[i] = EH'(eo); r.mh[i] = MH'(mo); ov[2*i] = o; ud[2*i] = u;
      end
    end else if (b.mode == PRECISION_CONFIG_8B) begin
      for (int i = 0; i < 4; i++) begin
        lane_ref(MQ, EQ, int'($signed(b.eq[i])), int'(b.mq[i]), eo, mo, o, u);
        r.eq[i] = EQ'(eo); r.mq[i] = MQ'(mo); ov[i] = o; ud[i] = u;
      end
    end
  endfunction

  function automatic in_t rnd_in();
    in_t b;
    int  sel;
    sel = $urandom_range(0, 2);
    b.mode = (sel == 0) ? PRECISION_CONFIG_32B : (sel == 1) ? PRECISION_CONFIG_16B : PRECISION_CONFIG_8B;
    b.ef = (EF+1)'($urandom);
    b.mf = ($urandom_range(0, 7) == 0) ? '0 : (MF+2)'($urandom);
    for (int i = 0; i < 2; i++) begin
      b.eh[i] = (EH+1)'($urandom);
      b.mh[i] = ($urandom_range(0, 7) == 0) ? '0 : (MH+2)'($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      b.eq[i] = (EQ+1)'($urandom);
      b.mq[i] = ($urandom_range(0, 7) == 0) ? '0 : (MQ+2)'($urandom);
    end
    return b;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  task automatic send(input in_t b);
    int n;
    out_t r;
    logic [3:0] ov, ud;
    mode = b.mode; exp_full_in = b.ef; mant_full_in = b.mf;
    exp_half_in = b.eh; mant_half_in = b.mh;
    exp_quart_in = b.eq; mant_quart_in = b.mq;
    in_valid = 1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout got in_ready 0 want 1");
    end else begin
      ref_beat(b, r, ov, ud);
      exp_q.push_back(r);
      m_ovf |= ov; m_udf |= ud;
      accepted++;
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(posedge clk); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending want 0", name, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_flags();
    clr_flags = 1;
    @(posedge clk); #1;
    clr_flags = 0;
    m_ovf = '0; m_udf = '0;
  endtask

  // Monitor: every accepted output beat is compared against the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      mon_act = {mode_out, exp_full_out, mant_full_out, exp_half_out, mant_half_out,
                 exp_quart_out, mant_quart_out};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got %h want none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL sb_beat got %h want %h", mon_act, mon_exp);
        end
      end
      pop_cyc.push_back(cyc);
    end
  end

  initial begin
    in_t b, b3;
    int  acc0, n, p0;
    checks = 0; errors = 0; accepted = 0; m_ovf = '0; m_udf = '0;
    rst = 1; in_valid = 0; clr_flags = 0; rand_mode = 0; rdy_fix = 1;
    mode = '0; exp_full_in = '0; mant_full_in = '0; exp_half_in = '0;
    mant_half_in = '0; exp_quart_in = '0; mant_quart_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ovf", ovf_flags, 0);
    chk("rst_udf", udf_flags, 0);
    chk("rst_mant_full", mant_full_out, 0);

    // 8b lane0, plain pass-through, and output latency.
    b = '0; b.mode = PRECISION_CONFIG_8B; b.eq[0] = 5'd3; b.mq[0] = 6'b0_1011_0;
    send(b);
    @(posedge clk); #1;
    chk("lat_valid", out_valid, 1);
    chk("t1_exp", exp_quart_out[0], 3);
    chk("t1_mant", mant_quart_out[0], 4'b1011);
    chk("t1_lane1", mant_quart_out[1], 0);

    // Carry normalize without rounding, then tie-to-even round with mantissa carry-out.
    b = '0; b.mode = PRECISION_CONFIG_8B; b.eq[0] = 5'd3; b.mq[0] = 6'b1_0110_1;
    send(b);
    b.mq[0] = 6'b0_1111_1;
    send(b);
    @(posedge clk); #1;
    chk("t2_exp", exp_quart_out[0], 4);
    chk("t2_mant", mant_quart_out[0], 4'b1000);

    // Overflow on lane1, underflow on lane2, then flag clear.
    b3 = '0; b3.mode = PRECISION_CONFIG_8B;
    b3.eq[1] = 5'd7; b3.mq[1] = 6'b1_0100_0;
    b3.eq[2] = 5'b10111; b3.mq[2] = 6'b0_1000_0;
    b3.mq[0] = 6'b0_1000_0; b3.mq[3] = 6'b0_1000_0;
    send(b3);
    @(posedge clk); #1;
    chk("t3_ovf", ovf_flags, 4'b0010);
    chk("t3_udf", udf_flags, 4'b0100);
    chk("t3_exp1", exp_quart_out[1], 7);
    chk("t3_mant1", mant_quart_out[1], 4'b1111);
    chk("t3_exp2", exp_quart_out[2], 4'b1000);
    chk("t3_mant2", mant_quart_out[2], 0);
    clear_flags();
    chk("clr_ovf", ovf_flags, 0);
    chk("clr_udf", udf_flags, 0);
    drain("t3");

    // Mixed modes back to back.
    p0 = pop_cyc.size();
    b = rnd_in(); b.mode = PRECISION_CONFIG_32B; send(b);
    b = rnd_in(); b.mode = PRECISION_CONFIG_16B; send(b);
    b = rnd_in(); b.mode = PRECISION_CONFIG_8B;  send(b);
    drain("mixed");
    if (pop_cyc.size() >= p0 + 3) chk("mixed_b2b_span", pop_cyc[p0+2] - pop_cyc[p0], 2);
    else chk("mixed_pops", pop_cyc.size() - p0, 3);

    // Output stall with four beats offered.
    clear_flags();
    rdy_fix = 0;
    acc0 = accepted;
    fork
      begin
        for (int i = 0; i < 4; i++) send(rnd_in());
      end
    join_none
    repeat (5) @(posedge clk);
    #2;
    chk("stall_accepted", accepted - acc0, 2);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    rdy_fix = 1;
    n = 0;
    while (accepted - acc0 < 4 && n < 100) begin @(posedge clk); n++; end
    chk("stall_all_accepted", accepted - acc0, 4);
    @(posedge clk); #2;
    drain("stall");

    // Reset with both stages occupied.
    clear_flags();
    rdy_fix = 0;
    send(b3);
    send(rnd_in());
    chk("pre_rst_ovf", ovf_flags, 4'b0010);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ovf", ovf_flags, 0);
    chk("mid_rst_udf", udf_flags, 0);
    exp_q.delete();
    m_ovf = '0; m_udf = '0;
    @(posedge clk); #1 rst = 0;
    rdy_fix = 1;
    chk("post_rst_in_ready", in_ready, 1);
    send(b3);
    @(posedge clk); #1;
    chk("post_rst_valid", out_valid, 1);
    drain("post_rst");

    // Randomized traffic with random backpressure.
    clear_flags();
    rand_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send(rnd_in());
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rand_mode = 0;
    drain("random");
    chk("rand_ovf", ovf_flags, m_ovf);
    chk("rand_udf", udf_flags, m_udf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
